// File: rtl/led_pwm_gpio_if.sv
// picorv32 native memory bus, as seen by the LED peripheral.
interface led_pwm_gpio_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/led_pwm_gpio.sv
// LED peripheral: per-LED direct on/off or 8-bit PWM brightness, with
// duty values double-buffered so a new duty only takes effect at a period
// boundary.

// One LED channel: shadow duty, comparator and the registered LED drive.
module led_pwm_ch (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_load,   // counter wraps to 0 at this edge
  input  logic [7:0] i_cnt,
  input  logic [7:0] i_duty,
  input  logic       i_mode,
  input  logic       i_out,
  output logic       o_led
);
  logic [7:0] r_shadow;
  logic       w_pwm;

  assign w_pwm = (i_cnt < r_shadow);

  // Shadow duty captures the live duty only at the period boundary.
  always_ff @(posedge clk) begin
    if (!resetn)     r_shadow <= 8'h00;
    else if (i_load) r_shadow <= i_duty;
  end

  // LED drive selects PWM or direct source, one register stage late.
  always_ff @(posedge clk) begin
    if (!resetn) o_led <= 1'b0;
    else         o_led <= i_mode ? w_pwm : i_out;
  end
endmodule

module led_pwm_gpio #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 16,
  parameter int unsigned NLED      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  led_pwm_gpio_if.slave    bus,
  output logic [NLED-1:0]  led
);
  logic                      r_ready;
  logic [31:0]               r_rdata;
  logic [7:0]                r_out;
  logic [7:0]                r_mode;
  logic [NLED-1:0][7:0]      r_duty;
  logic [15:0]               r_pre;
  logic [7:0]                r_cnt;

  logic       w_sel;
  logic       w_we;
  logic [7:0] w_off;
  logic [7:0] w_doff;
  logic [2:0] w_didx;
  logic       w_is_duty;
  logic [7:0] w_rd;
  logic       w_tick;
  logic       w_wrap;
  logic       w_unused;

  assign w_sel     = bus.mem_valid && (bus.mem_addr[31:8] == BASE_ADDR[31:8]) && !r_ready;
  // wstrb[0]=0 covers both reads and writes that miss the low byte.
  assign w_we      = w_sel && bus.mem_wstrb[0];
  assign w_off     = bus.mem_addr[7:0];
  assign w_doff    = w_off - 8'h10;
  assign w_didx    = w_doff[4:2];
  assign w_is_duty = (w_off >= 8'h10) && (w_off <= 8'h2C) && (w_off[1:0] == 2'b00);
  assign w_tick    = (r_pre == 16'(PRESCALE - 1));
  assign w_wrap    = w_tick && (r_cnt == 8'hFF);
  assign w_unused  = ^{bus.mem_wdata[31:8], bus.mem_wstrb[3:1]};

  assign bus.mem_ready = r_ready;
  assign bus.mem_rdata = r_rdata;

  // Read mux: decoded register byte, zero for unmapped offsets.
  always_comb begin
    w_rd = 8'h00;
    if      (w_off == 8'h00) w_rd = r_out;
    else if (w_off == 8'h04) w_rd = r_mode;
    else if (w_off == 8'h08) w_rd = r_cnt;
    else if (w_is_duty)      w_rd = r_duty[w_didx];
  end

  // One-cycle ack; read data only changes on an ack.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_ready <= w_sel;
      if (w_sel) r_rdata <= {24'h0, w_rd};
    end
  end

  // Register writes land on the same edge that raises mem_ready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out  <= 8'h00;
      r_mode <= 8'h00;
      r_duty <= '0;
    end else if (w_we) begin
      if      (w_off == 8'h00) r_out  <= bus.mem_wdata[7:0];
      else if (w_off == 8'h04) r_mode <= bus.mem_wdata[7:0];
      else if (w_is_duty)      r_duty[w_didx] <= bus.mem_wdata[7:0];
    end
  end

  // Prescaler and 8-bit PWM counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pre <= 16'h0;
      r_cnt <= 8'h00;
    end else if (w_tick) begin
      r_pre <= 16'h0;
      r_cnt <= r_cnt + 8'h01;
    end else begin
      r_pre <= r_pre + 16'h1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NLED; gi++) begin : g_ch
      led_pwm_ch u_ch (
        .clk    (clk),
        .resetn (resetn),
        .i_load (w_wrap),
        .i_cnt  (r_cnt),
        .i_duty (r_duty[gi]),
        .i_mode (r_mode[gi]),
        .i_out  (r_out[gi]),
        .o_led  (led[gi])
      );
    end
  endgenerate
endmodule
